// File: rtl/alu.sv
// 8-bit adder ALU: operand B is chosen by alusrc, and the sum plus the status
// flags are registered once per clock with a synchronous active-high reset.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] readdata1,
  input  logic [WIDTH-1:0] readdata2,
  input  logic [WIDTH-1:0] sign_extended,
  input  logic             alusrc,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  // Flags come straight from the 9-bit sum, so they always match the result
  // that is registered alongside them.
  function automatic flags_t derive_flags(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH:0]   s);
    flags_t f;
    f.carry    = s[WIDTH];
    f.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    f.zero     = (s[WIDTH-1:0] == '0);
    f.negative = s[WIDTH-1];
    return f;
  endfunction

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] out_d, out_q;
  flags_t           flags_d, flags_q;

  always_comb begin
    op_b    = alusrc ? sign_extended : readdata2;
    sum     = {1'b0, readdata1} + {1'b0, op_b};
    out_d   = sum[WIDTH-1:0];
    flags_d = derive_flags(readdata1, op_b, sum);
  end

  // Reset value keeps zero consistent with out = 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      flags_q <= '{carry: 1'b0, overflow: 1'b0, zero: 1'b1, negative: 1'b0};
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out      = out_q;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: each step drives inputs on the falling edge, clocks
// one rising edge, and checks the registered outputs shortly after it.
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] readdata1;
  logic [7:0] readdata2;
  logic [7:0] sign_extended;
  logic       alusrc;
  logic [7:0] out;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int checks   = 0;
  int failures = 0;

  alu #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .readdata1     (readdata1),
    .readdata2     (readdata2),
    .sign_extended (sign_extended),
    .alusrc        (alusrc),
    .out           (out),
    .carry         (carry),
    .overflow      (overflow),
    .zero          (zero),
    .negative      (negative)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] imm, input logic src);
    @(negedge clk);
    reset         = rst;
    readdata1     = a;
    readdata2     = b;
    sign_extended = imm;
    alusrc        = src;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_out,
                           input logic e_c, input logic e_v, input logic e_z,
                           input logic e_n);
    check({tag, ".out"}, out, e_out);
    check({tag, ".carry"}, {7'd0, carry}, {7'd0, e_c});
    check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, e_v});
    check({tag, ".zero"}, {7'd0, zero}, {7'd0, e_z});
    check({tag, ".negative"}, {7'd0, negative}, {7'd0, e_n});
  endtask

  initial begin
    reset = 1'b1; readdata1 = '0; readdata2 = '0; sign_extended = '0; alusrc = 1'b0;

    // reset for two edges
    drive(1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    step(); step();
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    step();
    check_all("zero_add", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 8'd41, 8'd12, 8'd0, 1'b0);
    step();
    check_all("add_41_12", 8'h35, 1'b0, 1'b0, 1'b0, 1'b0);

    // immediate path ignores readdata2
    drive(1'b0, 8'd0, 8'd12, 8'd3, 1'b1);
    step();
    check_all("imm_3", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    // toggling alusrc between edges must not move the registered output
    drive(1'b0, 8'd0, 8'd12, 8'd3, 1'b0);
    #1;
    check("hold_between_edges", out, 8'h03);
    step();
    check_all("reg_12", 8'h0c, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 8'd127, 8'd1, 8'd0, 1'b0);
    step();
    check_all("ovf_127_1", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 8'd200, 8'd100, 8'd0, 1'b0);
    step();
    check_all("carry_200_100", 8'd44, 1'b1, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 8'd255, 8'd1, 8'd0, 1'b0);
    step();
    check_all("wrap_255_1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // -128 + -128 via the immediate path: carry, overflow and zero together
    drive(1'b0, 8'h80, 8'h00, 8'h80, 1'b1);
    step();
    check_all("neg_ovf_imm", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    drive(1'b0, 8'hf0, 8'h00, 8'hfe, 1'b1);
    step();
    check_all("neg_sum_imm", 8'hee, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset mid-stream discards the in-flight 41+12
    drive(1'b1, 8'd41, 8'd12, 8'd0, 1'b0);
    step();
    check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 8'd41, 8'd12, 8'd0, 1'b0);
    step();
    check_all("after_reset", 8'h35, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit adder ALU in the single-cycle-style datapath of the course CPU.
- Adds register operand `readdata1` to a second operand.
  - Second operand is `readdata2` for register-register ops.
  - Second operand is `sign_extended` for immediate ops, selected by `alusrc`.
- Result and status flags are registered on the clock and go to writeback and branch logic.

Parameters:
- WIDTH, 8, data width of operands and result. All behaviour below is stated for WIDTH=8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registered outputs.
- readdata1  input  8  operand A, from register file read port 1.
- readdata2  input  8  operand B candidate, from register file read port 2.
- sign_extended  input  8  operand B candidate, the sign-extended immediate.
- alusrc  input  1  operand B select: 0 = `readdata2`, 1 = `sign_extended`.
- out  output  8  registered sum, A + B mod 256.
- carry  output  1  registered unsigned carry-out of bit 7.
- overflow  output  1  registered two's-complement overflow.
- zero  output  1  registered, 1 when `out` == 0.
- negative  output  1  registered copy of `out[7]`.

Behaviour:
- Operand B select is combinational: B = `alusrc` ? `sign_extended` : `readdata2`.
- 9-bit sum S = {0,A} + {0,B}; no carry-in.
- Rising clk with `reset`=1:
  - `out` = 8'h00.
  - `carry` = 0, `overflow` = 0, `negative` = 0.
  - `zero` = 1, consistent with `out` = 0.
  - Reset has priority over all inputs.
- Rising clk with `reset`=0:
  - `out` <= S[7:0].
  - `carry` <= S[8].
  - `overflow` <= (A[7] == B[7]) && (S[7] != A[7]).
  - `zero` <= (S[7:0] == 0).
  - `negative` <= S[7].
- Latency: exactly 1 cycle from stable inputs to outputs.
- No handshake; the block computes every cycle with no enable.
- Outputs hold between edges and never change combinationally with inputs.
- Wrap-around: results are modulo 256 (e.g. 255+1 gives `out`=0, `carry`=1, `zero`=1).
- `alusrc` changing between edges has no effect until the next edge; the mux value sampled at the edge is used.
- Reset asserted mid-stream: the next edge clears outputs and discards the in-flight result. The first non-reset edge after deassert loads a fresh result.
- X/unknown inputs are not defined; callers must drive all inputs.
- Implementation: one combinational mux and adder, one output register block with a flag-derivation function. No latches; no asynchronous logic.

Test Plan:
- Reset for 2 cycles with all inputs 0 -> `out`=0, `zero`=1, other flags 0. Then inputs 0 without reset -> `out`=0, `zero`=1, `carry`=0.
- `readdata1`=41, `readdata2`=12, `alusrc`=0 -> after 1 edge `out`=53 (0x35), all flags 0.
- `readdata1`=0, `sign_extended`=3, `alusrc`=1, `readdata2`=12 -> `out`=3, proving `readdata2` is ignored. Toggle `alusrc` to 0 -> next edge `out`=12.
- `readdata1`=127, `readdata2`=1 -> `out`=128 (0x80), `overflow`=1, `negative`=1, `carry`=0.
- `readdata1`=200, `readdata2`=100 -> `out`=44, `carry`=1, `overflow`=0. Then 255+1 -> `out`=0, `carry`=1, `zero`=1.
- Mid-stream `reset`=1 while computing 41+12 -> `out`=0 on that edge. Deassert -> next edge `out`=53.
